// File: rtl/icache_nway_ctlr.sv
// rtl/icache_nway_ctlr.sv - N-way set-associative L1 icache control FSM (hit detect, victim select, line refill)
module icache_nway_ctlr #(
   parameter int         S          = 64,
   parameter int         E          = 4,
   parameter int         B          = 4,
   parameter logic [1:0] NON_BRANCH = 2'b00
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic [$clog2(S)-1:0] set_i,
   input  logic [E-1:0]         tag_match_i,
   input  logic [E-1:0]         valid_i,
   input  logic [1:0]           pc_src_reg_i,
   input  logic [1:0]           branch_op_e_i,
   input  logic                 mem_valid_i,
   output logic                 instr_hit_f_o,
   output logic                 stall_f_o,
   output logic                 mem_req_o,
   output logic                 refill_we_o,
   output logic [E-1:0]         refill_way_o,
   output logic [$clog2(S)-1:0] refill_set_o,
   output logic [$clog2(B)-1:0] refill_word_o,
   output logic                 refill_last_o
);

   localparam int LOG_S = $clog2(S);
   localparam int LOG_E = $clog2(E);
   localparam int LOG_B = $clog2(B);

   typedef enum logic [1:0] {ST_IDLE, ST_BR_WAIT, ST_REFILL} state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [E-2:0]     r_plru [S];
   logic [LOG_S-1:0] r_set;
   logic [LOG_E-1:0] r_way;
   logic [E-1:0]     r_way_oh;
   logic [LOG_B-1:0] r_beat;
   logic [LOG_B-1:0] r_word;

   logic [E-1:0]     w_hit_vec;
   logic             w_hit;
   logic [LOG_E-1:0] w_hit_way;
   logic             w_has_inv;
   logic [LOG_E-1:0] w_inv_way;
   logic [LOG_E-1:0] w_victim;
   logic [E-1:0]     w_victim_oh;
   logic             w_latch;
   logic             w_beat;
   logic             w_last;
   logic             w_unused;

   // Tree walk from the root: a 0 bit steps toward the lower-index half, a 1 bit toward the upper half.
   function automatic logic [LOG_E-1:0] plru_victim(input logic [E-2:0] bits);
      int               node;
      logic             b;
      logic [LOG_E-1:0] way;
      node = 0;
      way  = '0;
      for (int l = 0; l < LOG_E; l++) begin
         b    = bits[LOG_E'(node)];
         way  = LOG_E'({way, b});
         node = 2 * node + 1 + int'(b);
      end
      return way;
   endfunction

   // Rewrite every node on the path to the given way so it points into the opposite subtree.
   function automatic logic [E-2:0] plru_touch(input logic [E-2:0] bits, input logic [LOG_E-1:0] way);
      logic [E-2:0]     res;
      logic [LOG_E-1:0] dir;
      int               node;
      res = bits;
      for (int l = 0; l < LOG_E; l++) begin
         node = (1 << l) - 1 + int'(way >> (LOG_E - l));
         dir  = way >> (LOG_E - 1 - l);
         res[LOG_E'(node)] = ~dir[0];
      end
      return res;
   endfunction

   assign w_hit_vec = tag_match_i & valid_i;
   assign w_hit     = |w_hit_vec;
   assign w_unused  = pc_src_reg_i[0];

   // Lowest-index hit way and lowest-index invalid way; the PLRU tree only decides when the set is full.
   always_comb begin
      w_hit_way = '0;
      w_inv_way = '0;
      w_has_inv = 1'b0;
      for (int i = E - 1; i >= 0; i--) begin
         if (w_hit_vec[i]) begin
            w_hit_way = LOG_E'(i);
         end
         if (!valid_i[i]) begin
            w_inv_way = LOG_E'(i);
            w_has_inv = 1'b1;
         end
      end
      w_victim    = w_has_inv ? w_inv_way : plru_victim(r_plru[set_i]);
      w_victim_oh = E'(1) << w_victim;
   end

   assign w_beat = (r_state == ST_REFILL) && mem_valid_i;
   assign w_last = w_beat && (r_beat == LOG_B'(B - 1));

   // Next state; a miss waits one cycle behind an unresolved branch, and a started refill always completes.
   always_comb begin
      w_state_nxt = r_state;
      w_latch     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (!w_hit && !pc_src_reg_i[1]) begin
               if (branch_op_e_i != NON_BRANCH) begin
                  w_state_nxt = ST_BR_WAIT;
               end else begin
                  w_state_nxt = ST_REFILL;
                  w_latch     = 1'b1;
               end
            end
         end
         ST_BR_WAIT: begin
            if (pc_src_reg_i[1]) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_state_nxt = ST_REFILL;
               w_latch     = 1'b1;
            end
         end
         ST_REFILL: begin
            if (w_last) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Refill target capture and beat counter; r_word keeps the last written offset visible after the line.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_set    <= '0;
         r_way    <= '0;
         r_way_oh <= '0;
         r_beat   <= '0;
         r_word   <= '0;
      end else begin
         if (w_latch) begin
            r_set    <= set_i;
            r_way    <= w_victim;
            r_way_oh <= w_victim_oh;
         end
         if (w_beat) begin
            r_word <= r_beat;
            r_beat <= r_beat + 1'b1;
         end
      end
   end

   // PLRU state: touched by a fetch hit in IDLE, or by the way a refill just completed.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         for (int s = 0; s < S; s++) begin
            r_plru[s] <= '0;
         end
      end else if ((r_state == ST_IDLE) && w_hit) begin
         r_plru[set_i] <= plru_touch(r_plru[set_i], w_hit_way);
      end else if (w_last) begin
         r_plru[r_set] <= plru_touch(r_plru[r_set], r_way);
      end
   end

   assign instr_hit_f_o = (r_state == ST_IDLE) && w_hit;
   assign stall_f_o     = ((r_state == ST_IDLE) && !w_hit && !pc_src_reg_i[1]) ||
                          (r_state == ST_BR_WAIT) || (r_state == ST_REFILL);
   assign mem_req_o     = (r_state == ST_REFILL);
   assign refill_we_o   = w_beat;
   assign refill_last_o = w_last;
   assign refill_way_o  = r_way_oh;
   assign refill_set_o  = r_set;
   assign refill_word_o = (r_state == ST_REFILL) ? r_beat : r_word;

   a_tag_onehot: assert property (@(posedge clk_i) disable iff (reset_i) $onehot0(tag_match_i));

endmodule

// File: tb/tb_icache_nway_ctlr.sv
// tb/tb_icache_nway_ctlr.sv - directed self-checking bench for icache_nway_ctlr
module tb_icache_nway_ctlr;

   localparam int S = 64;
   localparam int E = 4;
   localparam int B = 4;

   logic       clk_i;
   logic       reset_i;
   logic [5:0] set_i;
   logic [3:0] tag_match_i;
   logic [3:0] valid_i;
   logic [1:0] pc_src_reg_i;
   logic [1:0] branch_op_e_i;
   logic       mem_valid_i;
   logic       instr_hit_f_o;
   logic       stall_f_o;
   logic       mem_req_o;
   logic       refill_we_o;
   logic [3:0] refill_way_o;
   logic [5:0] refill_set_o;
   logic [1:0] refill_word_o;
   logic       refill_last_o;

   int errors = 0;
   int checks = 0;

   icache_nway_ctlr #(.S(S), .E(E), .B(B)) dut (
      .clk_i         (clk_i),
      .reset_i       (reset_i),
      .set_i         (set_i),
      .tag_match_i   (tag_match_i),
      .valid_i       (valid_i),
      .pc_src_reg_i  (pc_src_reg_i),
      .branch_op_e_i (branch_op_e_i),
      .mem_valid_i   (mem_valid_i),
      .instr_hit_f_o (instr_hit_f_o),
      .stall_f_o     (stall_f_o),
      .mem_req_o     (mem_req_o),
      .refill_we_o   (refill_we_o),
      .refill_way_o  (refill_way_o),
      .refill_set_o  (refill_set_o),
      .refill_word_o (refill_word_o),
      .refill_last_o (refill_last_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   // Idle parking: a squashed miss keeps the FSM in IDLE without touching PLRU state.
   task automatic park();
      tag_match_i   = 4'b0000;
      valid_i       = 4'b0000;
      pc_src_reg_i  = 2'b10;
      branch_op_e_i = 2'b00;
      mem_valid_i   = 1'b0;
   endtask

   task automatic run_beats();
      for (int k = 0; k < 4; k++) begin
         mem_valid_i = 1'b1;
         cyc();
      end
      park();
   endtask

   task automatic test_reset();
      reset_i = 1'b1;
      set_i = 6'd0; tag_match_i = 4'b0; valid_i = 4'b0; pc_src_reg_i = 2'b00; branch_op_e_i = 2'b00; mem_valid_i = 1'b0;
      #3;
      checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL rst_mem_req: got %b want 0", mem_req_o); end
      checks++; if (stall_f_o !== 1'b1) begin errors++; $display("FAIL rst_stall: got %b want 1", stall_f_o); end
      checks++; if (instr_hit_f_o !== 1'b0) begin errors++; $display("FAIL rst_hit: got %b want 0", instr_hit_f_o); end
      checks++; if (refill_way_o !== 4'b0000) begin errors++; $display("FAIL rst_way: got %b want 0000", refill_way_o); end
      checks++; if (refill_set_o !== 6'd0) begin errors++; $display("FAIL rst_set: got %0d want 0", refill_set_o); end
      checks++; if (refill_word_o !== 2'd0) begin errors++; $display("FAIL rst_word: got %0d want 0", refill_word_o); end
      checks++; if (refill_we_o !== 1'b0) begin errors++; $display("FAIL rst_we: got %b want 0", refill_we_o); end
      park();
      cyc();
      reset_i = 1'b0;
      cyc();
   endtask

   task automatic test_hit();
      set_i = 6'd5; valid_i = 4'b1111; pc_src_reg_i = 2'b00; branch_op_e_i = 2'b00;
      tag_match_i = 4'b0001;
      #1;
      checks++; if (instr_hit_f_o !== 1'b1) begin errors++; $display("FAIL hit0: got %b want 1", instr_hit_f_o); end
      checks++; if (stall_f_o !== 1'b0) begin errors++; $display("FAIL hit0_stall: got %b want 0", stall_f_o); end
      cyc();
      tag_match_i = 4'b0100;
      #1;
      checks++; if (instr_hit_f_o !== 1'b1) begin errors++; $display("FAIL hit2: got %b want 1", instr_hit_f_o); end
      checks++; if (stall_f_o !== 1'b0) begin errors++; $display("FAIL hit2_stall: got %b want 0", stall_f_o); end
      cyc();
      tag_match_i = 4'b0000; pc_src_reg_i = 2'b10;
      #1;
      checks++; if (stall_f_o !== 1'b0) begin errors++; $display("FAIL squash_stall: got %b want 0", stall_f_o); end
      cyc();
      checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL squash_req: got %b want 0", mem_req_o); end
      pc_src_reg_i = 2'b00;
      #1;
      checks++; if (stall_f_o !== 1'b1) begin errors++; $display("FAIL miss_stall: got %b want 1", stall_f_o); end
      cyc();
      checks++; if (mem_req_o !== 1'b1) begin errors++; $display("FAIL t1_req: got %b want 1", mem_req_o); end
      checks++; if (refill_way_o !== 4'b0010) begin errors++; $display("FAIL t1_plru_way: got %b want 0010", refill_way_o); end
      checks++; if (refill_set_o !== 6'd5) begin errors++; $display("FAIL t1_set: got %0d want 5", refill_set_o); end
      checks++; if (instr_hit_f_o !== 1'b0) begin errors++; $display("FAIL t1_hit_refill: got %b want 0", instr_hit_f_o); end
      run_beats();
   endtask

   task automatic test_refill();
      set_i = 6'd3; valid_i = 4'b1011; tag_match_i = 4'b0000; pc_src_reg_i = 2'b00; branch_op_e_i = 2'b00;
      #1;
      checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL t2_req_pre: got %b want 0", mem_req_o); end
      cyc();
      checks++; if (mem_req_o !== 1'b1) begin errors++; $display("FAIL t2_req: got %b want 1", mem_req_o); end
      checks++; if (refill_way_o !== 4'b0100) begin errors++; $display("FAIL t2_way: got %b want 0100", refill_way_o); end
      checks++; if (refill_set_o !== 6'd3) begin errors++; $display("FAIL t2_set: got %0d want 3", refill_set_o); end
      for (int k = 0; k < 4; k++) begin
         mem_valid_i = 1'b1;
         #1;
         checks++; if (refill_we_o !== 1'b1) begin errors++; $display("FAIL t2_we%0d: got %b want 1", k, refill_we_o); end
         checks++; if (refill_word_o !== k[1:0]) begin errors++; $display("FAIL t2_word%0d: got %0d want %0d", k, refill_word_o, k); end
         checks++; if (refill_last_o !== (k == 3)) begin errors++; $display("FAIL t2_last%0d: got %b want %b", k, refill_last_o, (k == 3)); end
         cyc();
         if (k == 0) begin
            mem_valid_i = 1'b0;
            #1;
            checks++; if (refill_we_o !== 1'b0) begin errors++; $display("FAIL t2_gap_we: got %b want 0", refill_we_o); end
            checks++; if (mem_req_o !== 1'b1) begin errors++; $display("FAIL t2_gap_req: got %b want 1", mem_req_o); end
            cyc();
         end
      end
      park();
      #1;
      checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL t2_idle_req: got %b want 0", mem_req_o); end
      checks++; if (refill_way_o !== 4'b0100) begin errors++; $display("FAIL t2_hold_way: got %b want 0100", refill_way_o); end
      checks++; if (refill_word_o !== 2'd3) begin errors++; $display("FAIL t2_hold_word: got %0d want 3", refill_word_o); end
      cyc();
   endtask

   task automatic test_branch();
      set_i = 6'd7; valid_i = 4'b0000; tag_match_i = 4'b0000; pc_src_reg_i = 2'b00; branch_op_e_i = 2'b01;
      #1;
      checks++; if (stall_f_o !== 1'b1) begin errors++; $display("FAIL t3_stall: got %b want 1", stall_f_o); end
      cyc();
      pc_src_reg_i = 2'b10;
      #1;
      checks++; if (stall_f_o !== 1'b1) begin errors++; $display("FAIL t3_brwait_stall: got %b want 1", stall_f_o); end
      checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL t3_brwait_req: got %b want 0", mem_req_o); end
      cyc();
      checks++; if (stall_f_o !== 1'b0) begin errors++; $display("FAIL t3_idle_stall: got %b want 0", stall_f_o); end
      branch_op_e_i = 2'b00;
      for (int k = 0; k < 2; k++) begin
         cyc();
         checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL t3_req%0d: got %b want 0", k, mem_req_o); end
      end
      pc_src_reg_i = 2'b00; branch_op_e_i = 2'b01;
      cyc();
      set_i = 6'd9; valid_i = 4'b0111; branch_op_e_i = 2'b00;
      #1;
      checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL t3b_req_pre: got %b want 0", mem_req_o); end
      cyc();
      checks++; if (mem_req_o !== 1'b1) begin errors++; $display("FAIL t3b_req: got %b want 1", mem_req_o); end
      checks++; if (refill_way_o !== 4'b1000) begin errors++; $display("FAIL t3b_way: got %b want 1000", refill_way_o); end
      checks++; if (refill_set_o !== 6'd9) begin errors++; $display("FAIL t3b_set: got %0d want 9", refill_set_o); end
      run_beats();
   endtask

   task automatic test_plru();
      logic [3:0] t;
      set_i = 6'd10; valid_i = 4'b1111; pc_src_reg_i = 2'b00; branch_op_e_i = 2'b00;
      for (int w = 0; w < 4; w++) begin
         t = 4'b0001 << w;
         tag_match_i = t;
         #1;
         checks++; if (instr_hit_f_o !== 1'b1) begin errors++; $display("FAIL t4_hit%0d: got %b want 1", w, instr_hit_f_o); end
         cyc();
      end
      tag_match_i = 4'b0000;
      cyc();
      checks++; if (refill_way_o !== 4'b0001) begin errors++; $display("FAIL t4_victim0: got %b want 0001", refill_way_o); end
      run_beats();
      set_i = 6'd10; valid_i = 4'b1111; pc_src_reg_i = 2'b00;
      cyc();
      checks++; if (refill_way_o !== 4'b0100) begin errors++; $display("FAIL t4_victim2: got %b want 0100", refill_way_o); end
      run_beats();
   endtask

   task automatic test_reset_mid();
      set_i = 6'd12; valid_i = 4'b0000; tag_match_i = 4'b0000; pc_src_reg_i = 2'b00; branch_op_e_i = 2'b00;
      cyc();
      checks++; if (mem_req_o !== 1'b1) begin errors++; $display("FAIL t5_req: got %b want 1", mem_req_o); end
      mem_valid_i = 1'b1;
      cyc();
      cyc();
      reset_i = 1'b1;
      #1;
      checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL t5_rst_req: got %b want 0", mem_req_o); end
      checks++; if (refill_we_o !== 1'b0) begin errors++; $display("FAIL t5_rst_we: got %b want 0", refill_we_o); end
      checks++; if (refill_way_o !== 4'b0000) begin errors++; $display("FAIL t5_rst_way: got %b want 0000", refill_way_o); end
      checks++; if (refill_word_o !== 2'd0) begin errors++; $display("FAIL t5_rst_word: got %0d want 0", refill_word_o); end
      park();
      cyc();
      reset_i = 1'b0;
      set_i = 6'd5; valid_i = 4'b1111; pc_src_reg_i = 2'b00;
      #1;
      checks++; if (stall_f_o !== 1'b1) begin errors++; $display("FAIL t5_post_stall: got %b want 1", stall_f_o); end
      cyc();
      checks++; if (refill_way_o !== 4'b0001) begin errors++; $display("FAIL t5_plru_clr: got %b want 0001", refill_way_o); end
      for (int k = 0; k < 4; k++) begin
         mem_valid_i = 1'b1;
         #1;
         checks++; if (refill_word_o !== k[1:0]) begin errors++; $display("FAIL t5_word%0d: got %0d want %0d", k, refill_word_o, k); end
         checks++; if (refill_last_o !== (k == 3)) begin errors++; $display("FAIL t5_last%0d: got %b want %b", k, refill_last_o, (k == 3)); end
         cyc();
      end
      park();
      cyc();
   endtask

   task automatic test_redirect();
      set_i = 6'd20; valid_i = 4'b0000; tag_match_i = 4'b0000; pc_src_reg_i = 2'b00; branch_op_e_i = 2'b00;
      cyc();
      checks++; if (refill_way_o !== 4'b0001) begin errors++; $display("FAIL t6_way: got %b want 0001", refill_way_o); end
      pc_src_reg_i = 2'b10;
      for (int k = 0; k < 4; k++) begin
         mem_valid_i = 1'b1;
         #1;
         checks++; if (mem_req_o !== 1'b1) begin errors++; $display("FAIL t6_req%0d: got %b want 1", k, mem_req_o); end
         checks++; if (refill_we_o !== 1'b1) begin errors++; $display("FAIL t6_we%0d: got %b want 1", k, refill_we_o); end
         checks++; if (refill_word_o !== k[1:0]) begin errors++; $display("FAIL t6_word%0d: got %0d want %0d", k, refill_word_o, k); end
         checks++; if (refill_last_o !== (k == 3)) begin errors++; $display("FAIL t6_last%0d: got %b want %b", k, refill_last_o, (k == 3)); end
         cyc();
      end
      park();
      #1;
      checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL t6_idle_req: got %b want 0", mem_req_o); end
      checks++; if (stall_f_o !== 1'b0) begin errors++; $display("FAIL t6_idle_stall: got %b want 0", stall_f_o); end
      cyc();
   endtask

   initial begin
      test_reset();
      test_hit();
      test_refill();
      test_branch();
      test_plru();
      test_reset_mid();
      test_redirect();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
